// File: rtl/multicycle_alu_if.sv
// Handshake and operand/result bundle between the control unit (master)
// and the multicycle ALU (slave).
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       ctrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] zHI;
  logic [WIDTH-1:0] zLOW;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, ctrl, A, B,
    input  zHI, zLOW, busy, done, div_by_zero
  );

  modport slave (
    input  start, ctrl, A, B,
    output zHI, zLOW, busy, done, div_by_zero
  );
endinterface

// File: rtl/multicycle_alu.sv
// Registered ALU: single-cycle logic/shift/add ops plus iterative signed
// multiply (shift-add) and divide (restoring) on operand magnitudes.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             clr,
  multicycle_alu_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_MUL = 5'b00010;
  localparam logic [4:0] OP_DIV = 5'b00011;
  localparam logic [4:0] OP_SHR = 5'b00100;
  localparam logic [4:0] OP_SHL = 5'b00101;
  localparam logic [4:0] OP_ROR = 5'b00110;
  localparam logic [4:0] OP_ROL = 5'b00111;
  localparam logic [4:0] OP_AND = 5'b01000;
  localparam logic [4:0] OP_OR  = 5'b01001;
  localparam logic [4:0] OP_NEG = 5'b01010;
  localparam logic [4:0] OP_NOT = 5'b01011;

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] rot_r(input logic [WIDTH-1:0] a, input logic [SHW-1:0] amt);
    logic [2*WIDTH-1:0] d;
    d = {a, a} >> amt;
    return d[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] rot_l(input logic [WIDTH-1:0] a, input logic [SHW-1:0] amt);
    logic [2*WIDTH-1:0] d;
    d = {a, a} << amt;
    return d[2*WIDTH-1:WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] simple_op(input logic [4:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic [SHW-1:0]   amt;
    amt = b[SHW-1:0];
    r   = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SHR:  r = a >> amt;
      OP_SHL:  r = a << amt;
      OP_ROR:  r = rot_r(a, amt);
      OP_ROL:  r = rot_l(a, amt);
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NEG:  r = -a;
      OP_NOT:  r = ~a;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             busy_r, busy_nx;
  logic             done_r, done_nx;
  logic             dbz_r, dbz_nx;
  logic [WIDTH-1:0] zhi_r, zhi_nx;
  logic [WIDTH-1:0] zlo_r, zlo_nx;
  logic             load, step_en;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        a_mag, b_mag;
  logic                    is_long, is_dbz, is_known;

  // Capture stage: operand magnitudes and result signs
  logic             is_div_p0, neg_q_p0, neg_r_p0;
  logic [WIDTH-1:0] b_mag_p0;
  // Iteration stage: hi = partial product high / remainder, lo = multiplier / quotient
  logic [WIDTH-1:0] hi_p1, lo_p1;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   rem_sh, step_hi, step_lo;
  logic               ge;
  logic [2*WIDTH-1:0] prod_fix;

  assign a_s      = bus.A;
  assign b_s      = bus.B;
  assign a_mag    = mag(a_s);
  assign b_mag    = mag(b_s);
  assign is_dbz   = (bus.ctrl == OP_DIV) && (bus.B == '0);
  assign is_long  = (bus.ctrl == OP_MUL) || ((bus.ctrl == OP_DIV) && !is_dbz);
  assign is_known = (bus.ctrl <= OP_NOT);

  always_comb begin
    sum    = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, b_mag_p0} : {(WIDTH+1){1'b0}});
    rem_sh = {hi_p1[WIDTH-2:0], lo_p1[WIDTH-1]};
    ge     = (rem_sh >= b_mag_p0);
    if (is_div_p0) begin
      step_hi = ge ? (rem_sh - b_mag_p0) : rem_sh;
      step_lo = {lo_p1[WIDTH-2:0], ge};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], lo_p1[WIDTH-1:1]};
    end
    prod_fix = cond_neg2({step_hi, step_lo}, neg_q_p0);
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    busy_nx  = busy_r;
    done_nx  = 1'b0;
    dbz_nx   = dbz_r;
    zhi_nx   = zhi_r;
    zlo_nx   = zlo_r;
    load     = 1'b0;
    step_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (is_long) begin
            load     = 1'b1;
            cnt_nx   = CW'(WIDTH);
            busy_nx  = 1'b1;
            state_nx = ITER;
          end else begin
            done_nx  = 1'b1;
            dbz_nx   = is_dbz;
            state_nx = DONE;
            if (is_dbz) begin
              zhi_nx = bus.A;
              zlo_nx = '1;
            end else if (is_known) begin
              zhi_nx = '0;
              zlo_nx = simple_op(bus.ctrl, bus.A, bus.B);
            end
          end
        end
      end
      ITER: begin
        step_en = 1'b1;
        cnt_nx  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nx = DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          dbz_nx   = 1'b0;
          if (is_div_p0) begin
            zhi_nx = cond_neg(step_hi, neg_r_p0);
            zlo_nx = cond_neg(step_lo, neg_q_p0);
          end else begin
            {zhi_nx, zlo_nx} = prod_fix;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      zhi_r  <= '0;
      zlo_r  <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      busy_r <= busy_nx;
      done_r <= done_nx;
      dbz_r  <= dbz_nx;
      zhi_r  <= zhi_nx;
      zlo_r  <= zlo_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      is_div_p0 <= (bus.ctrl == OP_DIV);
      neg_q_p0  <= a_s[WIDTH-1] ^ b_s[WIDTH-1];
      neg_r_p0  <= a_s[WIDTH-1];
      b_mag_p0  <= b_mag;
      hi_p1     <= '0;
      lo_p1     <= a_mag;
    end else if (step_en) begin
      hi_p1 <= step_hi;
      lo_p1 <= step_lo;
    end
  end

  assign bus.zHI         = zhi_r;
  assign bus.zLOW        = zlo_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu at WIDTH=32 and WIDTH=16.
module tb_multicycle_alu;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, MUL = 5'b00010, DIV = 5'b00011;
  localparam logic [4:0] SHR = 5'b00100, SHL = 5'b00101, ROR = 5'b00110, ROL = 5'b00111;
  localparam logic [4:0] AND_ = 5'b01000, OR_ = 5'b01001, NEG = 5'b01010, NOT_ = 5'b01011;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  multicycle_alu_if #(.WIDTH(32)) bus32();
  multicycle_alu_if #(.WIDTH(16)) bus16();

  multicycle_alu #(.WIDTH(32)) dut32 (.clk(clk), .clr(clr), .bus(bus32));
  multicycle_alu #(.WIDTH(16)) dut16 (.clk(clk), .clr(clr), .bus(bus16));

  always #5 clk = ~clk;

  // Drives one start pulse; returns just after the accepting edge E0.
  task automatic issue32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus32.start = 1'b1; bus32.ctrl = op; bus32.A = a; bus32.B = b;
    @(posedge clk); #1;
    bus32.start = 1'b0;
  endtask

  // lat = index k of the edge E(k) after which done is high; -1 if not within max edges.
  task automatic wait_done32(input int max, output int lat);
    lat = -1;
    if (bus32.done === 1'b1) lat = 0;
    else begin
      for (int i = 1; i <= max; i++) begin
        @(posedge clk); #1;
        if (bus32.done === 1'b1) begin lat = i; break; end
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus32.start = 0; bus32.ctrl = 0; bus32.A = 0; bus32.B = 0;
    bus16.start = 0; bus16.ctrl = 0; bus16.A = 0; bus16.B = 0;
    #3;
    checks++; if (bus32.zHI !== 32'h0) begin errors++; $display("FAIL reset_zhi: got %h want 0", bus32.zHI); end
    checks++; if (bus32.zLOW !== 32'h0) begin errors++; $display("FAIL reset_zlow: got %h want 0", bus32.zLOW); end
    checks++; if (bus32.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus32.busy); end
    checks++; if (bus32.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus32.done); end
    checks++; if (bus32.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", bus32.div_by_zero); end
    checks++; if (bus16.zLOW !== 16'h0) begin errors++; $display("FAIL reset16_zlow: got %h want 0", bus16.zLOW); end
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    issue32(ADD, 32'd5, 32'd7);
    checks++; if (bus32.busy !== 1'b0) begin errors++; $display("FAIL add_busy: got %b want 0", bus32.busy); end
    wait_done32(4, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL add_latency: got %0d want 0", lat); end
    checks++; if (bus32.zLOW !== 32'd12) begin errors++; $display("FAIL add_zlow: got %h want 0000000c", bus32.zLOW); end
    checks++; if (bus32.zHI !== 32'd0) begin errors++; $display("FAIL add_zhi: got %h want 0", bus32.zHI); end
    @(posedge clk); #1;
    checks++; if (bus32.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b want 0", bus32.done); end
  endtask

  task automatic test_simple_ops();
    logic [4:0]  ops [7] = '{SUB, AND_, OR_, NEG, NOT_, SHL, SHR};
    logic [31:0] av  [7] = '{32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'd1, 32'h12345678, 32'h80000001, 32'h80000001};
    logic [31:0] bv  [7] = '{32'd7, 32'h0FF00FF0, 32'h0FF00FF0, 32'd0, 32'd0, 32'd4, 32'h24};
    logic [31:0] ev  [7] = '{32'hFFFFFFFE, 32'h00F000F0, 32'hFFF0FFF0, 32'hFFFFFFFF, 32'hEDCBA987,
                             32'h00000010, 32'h08000000};
    int lat;
    for (int i = 0; i < 7; i++) begin
      issue32(ops[i], av[i], bv[i]);
      wait_done32(4, lat);
      checks++; if (lat !== 0) begin errors++; $display("FAIL simple_latency[%0d]: got %0d want 0", i, lat); end
      checks++; if (bus32.zLOW !== ev[i]) begin errors++; $display("FAIL simple_zlow[%0d]: got %h want %h", i, bus32.zLOW, ev[i]); end
      checks++; if (bus32.zHI !== 32'h0) begin errors++; $display("FAIL simple_zhi[%0d]: got %h want 0", i, bus32.zHI); end
    end
  endtask

  task automatic test_mul();
    int lat = -1;
    issue32(MUL, 32'hFFFFFFFD, 32'd7);
    bus32.A = 32'h12345678; bus32.B = 32'h0BADF00D;
    checks++; if (bus32.busy !== 1'b1) begin errors++; $display("FAIL mul_busy: got %b want 1", bus32.busy); end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin bus32.start = 1'b1; bus32.ctrl = ADD; bus32.A = 32'd1; bus32.B = 32'd1; end
      if (k == 5) bus32.start = 1'b0;
      if (bus32.done === 1'b1) begin lat = k; break; end
    end
    checks++; if (lat !== 32) begin errors++; $display("FAIL mul_latency: got %0d want 32", lat); end
    checks++; if (bus32.zHI !== 32'hFFFFFFFF) begin errors++; $display("FAIL mul_zhi: got %h want ffffffff", bus32.zHI); end
    checks++; if (bus32.zLOW !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_zlow: got %h want ffffffeb", bus32.zLOW); end
    checks++; if (bus32.busy !== 1'b0) begin errors++; $display("FAIL mul_busy_end: got %b want 0", bus32.busy); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus32.done !== 1'b0 || bus32.zLOW !== 32'hFFFFFFEB) begin
        errors++; $display("FAIL mul_after[%0d]: got done=%b zlow=%h want done=0 zlow=ffffffeb", k, bus32.done, bus32.zLOW);
      end
    end
  endtask

  task automatic test_div();
    int lat;
    issue32(DIV, 32'd17, 32'hFFFFFFFB);
    wait_done32(40, lat);
    checks++; if (lat !== 32) begin errors++; $display("FAIL div_latency: got %0d want 32", lat); end
    checks++; if (bus32.zLOW !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_quot: got %h want fffffffd", bus32.zLOW); end
    checks++; if (bus32.zHI !== 32'd2) begin errors++; $display("FAIL div_rem: got %h want 00000002", bus32.zHI); end
    checks++; if (bus32.div_by_zero !== 1'b0) begin errors++; $display("FAIL div_dbz: got %b want 0", bus32.div_by_zero); end
    issue32(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done32(40, lat);
    checks++; if (bus32.zLOW !== 32'h80000000) begin errors++; $display("FAIL div_ovf_quot: got %h want 80000000", bus32.zLOW); end
    checks++; if (bus32.zHI !== 32'h0) begin errors++; $display("FAIL div_ovf_rem: got %h want 0", bus32.zHI); end
  endtask

  task automatic test_div_zero();
    int lat;
    issue32(DIV, 32'd9, 32'd0);
    wait_done32(4, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL dbz_latency: got %0d want 0", lat); end
    checks++; if (bus32.zLOW !== 32'hFFFFFFFF) begin errors++; $display("FAIL dbz_zlow: got %h want ffffffff", bus32.zLOW); end
    checks++; if (bus32.zHI !== 32'd9) begin errors++; $display("FAIL dbz_zhi: got %h want 00000009", bus32.zHI); end
    checks++; if (bus32.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b want 1", bus32.div_by_zero); end
    issue32(ADD, 32'd1, 32'd1);
    wait_done32(4, lat);
    checks++; if (bus32.div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_clear: got %b want 0", bus32.div_by_zero); end
    checks++; if (bus32.zLOW !== 32'd2) begin errors++; $display("FAIL dbz_next_add: got %h want 00000002", bus32.zLOW); end
  endtask

  task automatic test_rotate();
    int lat;
    issue32(ROL, 32'h80000001, 32'd4);
    wait_done32(4, lat);
    checks++; if (bus32.zLOW !== 32'h00000018) begin errors++; $display("FAIL rol: got %h want 00000018", bus32.zLOW); end
    issue32(ROR, 32'h80000001, 32'd4);
    wait_done32(4, lat);
    checks++; if (bus32.zLOW !== 32'h18000000) begin errors++; $display("FAIL ror: got %h want 18000000", bus32.zLOW); end
    issue32(SHR, 32'h80000001, 32'd0);
    wait_done32(4, lat);
    checks++; if (bus32.zLOW !== 32'h80000001) begin errors++; $display("FAIL shr0: got %h want 80000001", bus32.zLOW); end
    issue32(5'b11111, 32'h0000FFFF, 32'h0000FFFF);
    wait_done32(4, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL undef_done: got %0d want 0", lat); end
    checks++; if (bus32.zLOW !== 32'h80000001) begin errors++; $display("FAIL undef_zlow: got %h want 80000001", bus32.zLOW); end
    checks++; if (bus32.zHI !== 32'h0) begin errors++; $display("FAIL undef_zhi: got %h want 0", bus32.zHI); end
  endtask

  task automatic test_back_to_back();
    logic exp_done;
    @(posedge clk); #1;
    bus32.start = 1'b1; bus32.ctrl = ADD; bus32.A = 32'd1; bus32.B = 32'd2;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_done = (i % 2 == 0);
      checks++; if (bus32.done !== exp_done) begin errors++; $display("FAIL b2b_done[%0d]: got %b want %b", i, bus32.done, exp_done); end
    end
    bus32.start = 1'b0;
    checks++; if (bus32.zLOW !== 32'd3) begin errors++; $display("FAIL b2b_zlow: got %h want 00000003", bus32.zLOW); end
  endtask

  task automatic test_abort();
    int lat;
    int dones = 0;
    issue32(MUL, 32'd5, 32'd6);
    for (int k = 1; k <= 10; k++) begin @(posedge clk); #1; end
    clr = 1'b1;
    #1;
    checks++;
    if (bus32.zHI !== 32'h0 || bus32.zLOW !== 32'h0 || bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin
      errors++; $display("FAIL abort_async: got zhi=%h zlow=%h busy=%b done=%b want all 0", bus32.zHI, bus32.zLOW, bus32.busy, bus32.done);
    end
    @(posedge clk); #1;
    clr = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus32.done === 1'b1 || bus32.busy === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", dones); end
    issue32(ADD, 32'd2, 32'd3);
    wait_done32(4, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL abort_add_latency: got %0d want 0", lat); end
    checks++; if (bus32.zLOW !== 32'd5) begin errors++; $display("FAIL abort_add_zlow: got %h want 00000005", bus32.zLOW); end
  endtask

  task automatic test_mul16();
    int lat = -1;
    @(posedge clk); #1;
    bus16.start = 1'b1; bus16.ctrl = MUL; bus16.A = 16'h7FFF; bus16.B = 16'h7FFF;
    @(posedge clk); #1;
    bus16.start = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (bus16.done === 1'b1) begin lat = k; break; end
    end
    checks++; if (lat !== 16) begin errors++; $display("FAIL mul16_latency: got %0d want 16", lat); end
    checks++; if (bus16.zHI !== 16'h3FFF) begin errors++; $display("FAIL mul16_zhi: got %h want 3fff", bus16.zHI); end
    checks++; if (bus16.zLOW !== 16'h0001) begin errors++; $display("FAIL mul16_zlow: got %h want 0001", bus16.zLOW); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_simple_ops();
    test_mul();
    test_div();
    test_div_zero();
    test_rotate();
    test_back_to_back();
    test_abort();
    test_mul16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
